// File: rtl/roberto_uc.sv
// Control unit for the three-sensor ultrasonic ranging datapath.
// It runs a once-per-second cycle: measure all three sensors, then send a 12-character frame.
module roberto_uc #(
    parameter int TIMEOUT = 2_500_000
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       ligar_i,
    input  logic       pronto_medida1_i,
    input  logic       pronto_medida2_i,
    input  logic       pronto_medida3_i,
    input  logic       pronto_serial_i,
    input  logic       pronto_seg_i,
    output logic       zera_sensor_o,
    output logic       zera_serial_o,
    output logic       zera_seg_o,
    output logic       conta_seg_o,
    output logic       medir_o,
    output logic       partida_tx_o,
    output logic [1:0] sel_sensor_o,
    output logic [1:0] sel_digito_o,
    output logic       pronto_o,
    output logic       erro_timeout_o,
    output logic [3:0] db_estado_o
);

    // state | meaning
    // 0     | inicial: idle, waiting for ligar
    // 1     | preparacao: clear datapath, counters and flags
    // 2     | espera_seg: 1 s counter running
    // 3     | medir: start all three measurements
    // 4     | aguarda_medida: collect done pulses, run timeout
    // 5     | transmite: start one character
    // 6     | espera_tx: wait for the transmitter
    // 7     | proximo: advance digit / sensor
    // 8     | fim_ciclo: frame complete
    // 9     | erro: measurement round timed out
    localparam logic [3:0] S_INICIAL    = 4'd0;
    localparam logic [3:0] S_PREPARACAO = 4'd1;
    localparam logic [3:0] S_ESPERA_SEG = 4'd2;
    localparam logic [3:0] S_MEDIR      = 4'd3;
    localparam logic [3:0] S_AGUARDA    = 4'd4;
    localparam logic [3:0] S_TRANSMITE  = 4'd5;
    localparam logic [3:0] S_ESPERA_TX  = 4'd6;
    localparam logic [3:0] S_PROXIMO    = 4'd7;
    localparam logic [3:0] S_FIM        = 4'd8;
    localparam logic [3:0] S_ERRO       = 4'd9;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [3:0]    estado_q, estado_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    flags_q, flags_d;
    logic [2:0]    flags_now;
    logic [1:0]    sel_sensor_q, sel_sensor_d;
    logic [1:0]    sel_digito_q, sel_digito_d;
    logic          erro_q, erro_d;
    logic          zera_q, conta_q, medir_q, partida_q, pronto_q;

    assign flags_now = flags_q | {pronto_medida3_i, pronto_medida2_i, pronto_medida1_i};

    always_comb begin
        estado_d     = estado_q;
        cnt_d        = cnt_q;
        flags_d      = flags_q;
        sel_sensor_d = sel_sensor_q;
        sel_digito_d = sel_digito_q;
        erro_d       = erro_q;
        case (estado_q)
            S_INICIAL: begin
                if (ligar_i) estado_d = S_PREPARACAO;
            end
            S_PREPARACAO: begin
                sel_sensor_d = 2'd0;
                sel_digito_d = 2'd0;
                flags_d      = 3'b000;
                erro_d       = 1'b0;
                cnt_d        = '0;
                estado_d     = S_ESPERA_SEG;
            end
            S_ESPERA_SEG: begin
                if (!ligar_i)          estado_d = S_INICIAL;
                else if (pronto_seg_i) estado_d = S_MEDIR;
            end
            S_MEDIR: begin
                flags_d  = 3'b000;
                cnt_d    = '0;
                estado_d = S_AGUARDA;
            end
            S_AGUARDA: begin
                flags_d = flags_now;
                cnt_d   = cnt_q + CW'(1);
                // a pulse landing on the last counted cycle still wins over the timeout
                if (&flags_now) begin
                    sel_sensor_d = 2'd3;
                    sel_digito_d = 2'd3;
                    estado_d     = S_TRANSMITE;
                end else if (cnt_q == CNT_LAST) begin
                    sel_sensor_d = 2'd0;
                    erro_d       = 1'b1;
                    estado_d     = S_ERRO;
                end
            end
            S_TRANSMITE: begin
                estado_d = S_ESPERA_TX;
            end
            S_ESPERA_TX: begin
                if (pronto_serial_i) estado_d = S_PROXIMO;
            end
            S_PROXIMO: begin
                if (sel_digito_q != 2'd0) begin
                    sel_digito_d = sel_digito_q - 2'd1;
                    estado_d     = S_TRANSMITE;
                end else if (sel_sensor_q != 2'd1) begin
                    sel_sensor_d = sel_sensor_q - 2'd1;
                    sel_digito_d = 2'd3;
                    estado_d     = S_TRANSMITE;
                end else begin
                    estado_d = S_FIM;
                end
            end
            S_FIM: begin
                sel_sensor_d = 2'd0;
                estado_d     = S_ESPERA_SEG;
            end
            S_ERRO: begin
                sel_sensor_d = 2'd0;
                estado_d     = S_ESPERA_SEG;
            end
            default: begin
                estado_d = S_INICIAL;
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            estado_q     <= S_INICIAL;
            cnt_q        <= '0;
            flags_q      <= 3'b000;
            sel_sensor_q <= 2'd0;
            sel_digito_q <= 2'd0;
            erro_q       <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            cnt_q        <= cnt_d;
            flags_q      <= flags_d;
            sel_sensor_q <= sel_sensor_d;
            sel_digito_q <= sel_digito_d;
            erro_q       <= erro_d;
        end
    end

    // Strobes are decoded from the current state and registered, so they trail the state by one cycle.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            zera_q    <= 1'b0;
            conta_q   <= 1'b0;
            medir_q   <= 1'b0;
            partida_q <= 1'b0;
            pronto_q  <= 1'b0;
        end else begin
            zera_q    <= (estado_q == S_PREPARACAO);
            conta_q   <= (estado_q == S_ESPERA_SEG);
            medir_q   <= (estado_q == S_MEDIR);
            partida_q <= (estado_q == S_TRANSMITE);
            pronto_q  <= (estado_q == S_FIM);
        end
    end

    assign zera_sensor_o  = zera_q;
    assign zera_serial_o  = zera_q;
    assign zera_seg_o     = zera_q;
    assign conta_seg_o    = conta_q;
    assign medir_o        = medir_q;
    assign partida_tx_o   = partida_q;
    assign sel_sensor_o   = sel_sensor_q;
    assign sel_digito_o   = sel_digito_q;
    assign pronto_o       = pronto_q;
    assign erro_timeout_o = erro_q;
    assign db_estado_o    = estado_q;

endmodule

// File: tb/tb_roberto_uc.sv
// Bench for roberto_uc: directed and randomized measurement rounds against a frame-level model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_roberto_uc;

    localparam int T = 20;

    logic       clock_i = 1'b0;
    logic       reset_i;
    logic       ligar_i;
    logic       pronto_medida1_i, pronto_medida2_i, pronto_medida3_i;
    logic       pronto_serial_i;
    logic       pronto_seg_i;
    logic       zera_sensor_o, zera_serial_o, zera_seg_o, conta_seg_o;
    logic       medir_o, partida_tx_o, pronto_o, erro_timeout_o;
    logic [1:0] sel_sensor_o, sel_digito_o;
    logic [3:0] db_estado_o;

    roberto_uc #(.TIMEOUT(T)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .ligar_i(ligar_i),
        .pronto_medida1_i(pronto_medida1_i), .pronto_medida2_i(pronto_medida2_i),
        .pronto_medida3_i(pronto_medida3_i), .pronto_serial_i(pronto_serial_i),
        .pronto_seg_i(pronto_seg_i),
        .zera_sensor_o(zera_sensor_o), .zera_serial_o(zera_serial_o), .zera_seg_o(zera_seg_o),
        .conta_seg_o(conta_seg_o), .medir_o(medir_o), .partida_tx_o(partida_tx_o),
        .sel_sensor_o(sel_sensor_o), .sel_digito_o(sel_digito_o), .pronto_o(pronto_o),
        .erro_timeout_o(erro_timeout_o), .db_estado_o(db_estado_o)
    );

    always #5 clock_i = ~clock_i;

    int errors = 0;
    int checks = 0;
    int ncyc = 0;
    int part_cnt = 0;
    int pronto_cnt = 0;
    int pronto_t = 0;
    int cd = 0;
    int resp_delay = 4;
    int drop_at = 0;
    int part_t[$];
    logic [3:0] part_sd[$];
    logic exp_erro = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({zera_sensor_o, zera_serial_o, zera_seg_o, conta_seg_o, medir_o, partida_tx_o,
                    sel_sensor_o, sel_digito_o, pronto_o, erro_timeout_o, db_estado_o});
    endfunction

    // One falling edge: record transmitter starts/frame ends and play the serial transmitter.
    task automatic tick();
        @(negedge clock_i);
        ncyc++;
        pronto_serial_i = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) pronto_serial_i = 1'b1;
        end
        if (partida_tx_o === 1'b1) begin
            part_cnt++;
            part_t.push_back(ncyc);
            part_sd.push_back({sel_sensor_o, sel_digito_o});
            cd = resp_delay;
            if (drop_at != 0 && part_cnt == drop_at) ligar_i = 1'b0;
        end
        if (pronto_o === 1'b1) begin
            pronto_cnt++;
            pronto_t = ncyc;
        end
    endtask

    // One full round; o1..o3 are the cycles after medir at which each sensor answers.
    task automatic run_round(input int o1, input int o2, input int o3, input int dly);
        int w, m, mx, t, idx;
        logic ok;
        resp_delay = dly;
        w = 0;
        while (db_estado_o !== 4'd2 && w < 60) begin
            tick();
            w++;
        end
        chk("wait_espera_seg", 32'(db_estado_o), 32'd2);
        part_cnt = 0;
        pronto_cnt = 0;
        part_t.delete();
        part_sd.delete();
        pronto_seg_i = 1'b1;
        tick();
        pronto_seg_i = 1'b0;
        chk("medir_early", 32'(medir_o), 32'd0);
        tick();
        chk("medir_rise", 32'(medir_o), 32'd1);
        m = ncyc;
        mx = o1;
        if (o2 > mx) mx = o2;
        if (o3 > mx) mx = o3;
        ok = (mx <= T - 1);
        for (int off = 0; off <= T + 5; off++) begin
            pronto_medida1_i = (off == o1);
            pronto_medida2_i = (off == o2);
            pronto_medida3_i = (off == o3);
            tick();
            t = ncyc - m;
            if (t == 1) chk("medir_one_cycle", 32'(medir_o), 32'd0);
            if (!ok && t == T - 1) chk("erro_before_expiry", 32'(erro_timeout_o), 32'(exp_erro));
            if (!ok && t == T) chk("erro_at_expiry", 32'(erro_timeout_o), 32'd1);
            if (!ok && t == T + 1) chk("back_to_espera", 32'(db_estado_o), 32'd2);
        end
        pronto_medida1_i = 1'b0;
        pronto_medida2_i = 1'b0;
        pronto_medida3_i = 1'b0;
        if (!ok) exp_erro = 1'b1;
        if (ok) begin
            w = 0;
            while (pronto_cnt == 0 && w < 800) begin
                tick();
                w++;
            end
            chk("pronto_seen", 32'(pronto_cnt), 32'd1);
            chk("db_at_pronto", 32'(db_estado_o), 32'd2);
            chk("char_count", 32'(part_cnt), 32'd12);
            idx = 0;
            for (int s = 3; s >= 1; s--) begin
                for (int d = 3; d >= 0; d--) begin
                    chk("char_sel", (idx < part_sd.size()) ? 32'(part_sd[idx]) : 32'hFFFF, 32'(s * 4 + d));
                    idx++;
                end
            end
            chk("first_tx_latency", (part_t.size() > 0) ? 32'(part_t[0] - m) : 32'hFFFF, 32'(mx + 2));
            for (int i = 1; i < part_t.size(); i++)
                chk("char_gap", 32'(part_t[i] - part_t[i-1]), 32'(dly + 3));
            chk("pronto_latency", (part_t.size() > 0) ? 32'(pronto_t - part_t[part_t.size()-1]) : 32'hFFFF,
                32'(dly + 3));
            tick();
            chk("pronto_one_cycle", 32'(pronto_o), 32'd0);
            chk("erro_flag", 32'(erro_timeout_o), 32'(exp_erro));
        end else begin
            chk("no_tx_on_timeout", 32'(part_cnt), 32'd0);
            chk("no_pronto_on_timeout", 32'(pronto_cnt), 32'd0);
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog expired at cycle %0d", ncyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int w, p0;
        reset_i = 1'b0;
        ligar_i = 1'b0;
        pronto_medida1_i = 1'b0;
        pronto_medida2_i = 1'b0;
        pronto_medida3_i = 1'b0;
        pronto_serial_i = 1'b0;
        pronto_seg_i = 1'b0;
        repeat (3) tick();
        chk("reset_outputs", outs(), 32'd0);
        reset_i = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("idle_outputs", outs(), 32'd0);
        end

        ligar_i = 1'b1;
        tick();
        chk("prep_state", 32'(db_estado_o), 32'd1);
        tick();
        chk("zera_pulse", 32'({zera_sensor_o, zera_serial_o, zera_seg_o}), 32'd7);
        chk("conta_seg_not_yet", 32'(conta_seg_o), 32'd0);
        tick();
        chk("zera_clear", 32'({zera_sensor_o, zera_serial_o, zera_seg_o}), 32'd0);
        chk("conta_seg_on", 32'(conta_seg_o), 32'd1);

        run_round(5, 10, 15, 4);
        run_round(3, 7, 99, 4);
        run_round(1, 2, 3, 2);
        run_round(2, 4, T - 1, 4);
        run_round(T - 1, T - 1, T, 3);
        for (int r = 0; r < 6; r++)
            run_round(int'($urandom_range(0, T + 3)), int'($urandom_range(0, T + 3)),
                      int'($urandom_range(0, T + 3)), int'($urandom_range(1, 6)));

        drop_at = 5;
        run_round(4, 6, 8, 4);
        drop_at = 0;
        chk("ligar_drop_idle", 32'(db_estado_o), 32'd0);
        tick();
        chk("idle_after_drop", outs() & ~32'h10, 32'd0);
        chk("erro_kept_in_idle", 32'(erro_timeout_o), 32'(exp_erro));

        ligar_i = 1'b1;
        resp_delay = 50;
        pronto_seg_i = 1'b1;
        pronto_medida1_i = 1'b1;
        pronto_medida2_i = 1'b1;
        pronto_medida3_i = 1'b1;
        w = 0;
        while (db_estado_o !== 4'd6 && w < 60) begin
            tick();
            w++;
        end
        chk("reach_espera_tx", 32'(db_estado_o), 32'd6);
        pronto_seg_i = 1'b0;
        pronto_medida1_i = 1'b0;
        pronto_medida2_i = 1'b0;
        pronto_medida3_i = 1'b0;
        reset_i = 1'b0;
        cd = 0;
        #1;
        chk("reset_async", outs(), 32'd0);
        p0 = part_cnt;
        repeat (10) tick();
        chk("no_tx_in_reset", 32'(part_cnt), 32'(p0));
        reset_i = 1'b1;
        exp_erro = 1'b0;
        tick();
        chk("restart_prep", 32'(db_estado_o), 32'd1);
        repeat (5) tick();
        chk("no_tx_after_reset", 32'(part_cnt), 32'(p0));
        chk("erro_cleared_after_reset", 32'(erro_timeout_o), 32'(exp_erro));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
